// File: rtl/common.sv
// Shared data-bus types and helpers for the memory stage and its responders.
package common;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_WAIT,
    DS_RESP
  } DSRAM_STATE_T;

  // Only the low three address bits matter for alignment up to 8 bytes.
  function automatic logic size_misaligned(
    input logic [2:0] addr,
    input msize_t     size
  );
    case (size)
      MSIZE1:  return 1'b0;
      MSIZE2:  return addr[0];
      MSIZE4:  return |addr[1:0];
      MSIZE8:  return |addr[2:0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dbus_sram_responder_bank.sv
// Single-port 64-bit SRAM bank: byte-enable write, combinational read.
module dsram_bank #(
  parameter int DEPTH = 1024,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    strobe,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dbus_sram_responder.sv
// Default data-bus responder: latency-programmable byte-strobed 64-bit SRAM.
import common::*;

module dbus_sram_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int          IW       = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  DSRAM_STATE_T state, state_n;
  logic [3:0]   cnt;
  logic [63:0]  addr_q;
  msize_t       size_q;
  logic [7:0]   strobe_q;
  logic [63:0]  data_q;

  logic         accept;
  logic [63:0]  off;
  logic         bad;
  logic         we;
  logic [63:0]  rdata;

  assign accept = (state == DS_IDLE) && dreq.valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DS_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      addr_q   <= '0;
      size_q   <= MSIZE1;
      strobe_q <= '0;
      data_q   <= '0;
    end else if (accept) begin
      cnt      <= CNT_INIT;
      addr_q   <= dreq.addr;
      size_q   <= dreq.size;
      strobe_q <= dreq.strobe;
      data_q   <= dreq.data;
    end else if (state == DS_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      DS_IDLE: begin
        if (dreq.valid) state_n = (LATENCY == 1) ? DS_RESP : DS_WAIT;
      end
      DS_WAIT: begin
        // Initiator withdrawing the request cancels the access outright.
        if (!dreq.valid)      state_n = DS_IDLE;
        else if (cnt <= 4'd1) state_n = DS_RESP;
      end
      DS_RESP: state_n = DS_IDLE;
      default: state_n = DS_IDLE;
    endcase
  end

  assign off = addr_q - BASE_ADDR;
  assign bad = (addr_q < BASE_ADDR) || (off >= SPAN) ||
               size_misaligned(addr_q[2:0], size_q);
  assign we  = (state == DS_RESP) && !bad && (|strobe_q);

  dsram_bank #(
    .DEPTH (DEPTH_WORDS)
  ) u_bank (
    .clk    (clk),
    .we     (we),
    .idx    (off[IW+2:3]),
    .strobe (strobe_q),
    .wdata  (data_q),
    .rdata  (rdata)
  );

  always_comb begin
    dresp = '0;
    err   = 1'b0;
    if (state == DS_RESP) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = bad ? 64'h0 : rdata;
      err           = bad;
    end
  end

endmodule
